// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: DEPTH x 32-bit register-file memory with byte-lane writes and two-cycle ERROR.
// Optional wait states per accepted transfer are enabled by defining AHB_SLV_WAIT_EN.
module ahb_lite_sram_slave #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic        HREADY,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_e;

   state_e        state_q, state_d;
   logic          dp_valid_q, dp_valid_d;
   logic          dp_write_q, dp_write_d;
   logic [1:0]    dp_size_q, dp_size_d;
   logic [1:0]    dp_lane_q, dp_lane_d;
   logic [AW-1:0] dp_idx_q, dp_idx_d;
   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   mem_d [DEPTH];

   logic          accept;
   logic          addr_err;
   logic          complete;
   logic          wait_done;
   logic [3:0]    lane_en;
   logic          unused_bits;

   assign unused_bits = ^{HBURST, HTRANS[0]};

`ifdef AHB_SLV_WAIT_EN
   localparam bit WAIT_ON = (WAIT_CYCLES != 0);
   logic [3:0] wait_cnt_q, wait_cnt_d;

   assign wait_done = (wait_cnt_q == 4'd0);

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == ST_WAIT && !wait_done) begin
         wait_cnt_d = wait_cnt_q - 4'd1;
      end
      if (state_d == ST_WAIT && state_q != ST_WAIT) begin
         wait_cnt_d = 4'(WAIT_CYCLES - 1);
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   localparam bit WAIT_ON = 1'b0;
   assign wait_done = 1'b1;
`endif

   always_comb begin
      accept   = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) && HSEL && HREADY && HTRANS[1];
      addr_err = (HADDR[31:2] >= 30'(DEPTH))
              || (HSIZE > 3'd2)
              || ((HSIZE == 3'd1) && HADDR[0])
              || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
      // A pending data phase completes in the first IDLE cycle after its waits.
      complete = (state_q == ST_IDLE) && dp_valid_q;
   end

   always_comb begin
      state_d    = state_q;
      dp_valid_d = dp_valid_q;
      dp_write_d = dp_write_q;
      dp_size_d  = dp_size_q;
      dp_lane_d  = dp_lane_q;
      dp_idx_d   = dp_idx_q;
      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d    = ST_IDLE;
            dp_valid_d = accept && !addr_err;
            if (accept && addr_err) begin
               state_d = ST_ERR1;
            end else if (accept) begin
               dp_write_d = HWRITE;
               dp_size_d  = HSIZE[1:0];
               dp_lane_d  = HADDR[1:0];
               dp_idx_d   = HADDR[AW+1:2];
               if (WAIT_ON) begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wait_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      case (dp_size_q)
         2'd0:    lane_en = 4'b0001 << dp_lane_q;
         2'd1:    lane_en = dp_lane_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (complete && dp_write_q) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
               mem_d[dp_idx_q][8*b +: 8] = HWDATA[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
      HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
      HRDATA    = (complete && !dp_write_q) ? mem_q[dp_idx_q] : '0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_size_q  <= '0;
         dp_lane_q  <= '0;
         dp_idx_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_size_q  <= dp_size_d;
         dp_lane_q  <= dp_lane_d;
         dp_idx_q   <= dp_idx_d;
         mem_q      <= mem_d;
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench for ahb_lite_sram_slave: directed transfers push expected responses, a monitor checks them.
module tb_ahb_lite_sram_slave;

   localparam int unsigned DEPTH = 64;
`ifdef AHB_SLV_WAIT_EN
   localparam int unsigned EXP_WAITS = 2;
`else
   localparam int unsigned EXP_WAITS = 0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = '0;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = '0;
   logic [2:0]  HBURST = '0;
   logic [31:0] HWDATA = '0;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int unsigned waits;
      int unsigned id;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic        pend = 1'b0;
   int unsigned low_cnt = 0;
   int unsigned next_id = 0;

   ahb_lite_sram_slave #(
      .DEPTH(DEPTH),
      .WAIT_CYCLES(2)
   ) dut (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .HSEL(HSEL),
      .HREADY(HREADYOUT),
      .HADDR(HADDR),
      .HTRANS(HTRANS),
      .HWRITE(HWRITE),
      .HSIZE(HSIZE),
      .HBURST(HBURST),
      .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT),
      .HRESP(HRESP),
      .HRDATA(HRDATA)
   );

   initial forever #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: tracks the data phase of each accepted transfer and checks it against the scoreboard.
   initial forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_underflow: got data phase with empty scoreboard expected entry");
               pend = 1'b0;
            end else if (HREADYOUT) begin
               exp_t e;
               e = exp_q.pop_front();
               chk($sformatf("x%0d_resp", e.id), 32'(HRESP), 32'(e.err));
               chk($sformatf("x%0d_rdata", e.id), HRDATA, e.data);
               chk($sformatf("x%0d_waits", e.id), low_cnt, e.waits);
               pend = 1'b0;
            end else begin
               low_cnt++;
               chk($sformatf("x%0d_lowresp", exp_q[0].id), 32'(HRESP), 32'(exp_q[0].err));
               if (low_cnt > 40) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL x%0d_timeout: got HREADYOUT low 41 cycles expected completion", exp_q[0].id);
                  void'(exp_q.pop_front());
                  pend = 1'b0;
               end
            end
         end else begin
            chk("idle_ready", 32'(HREADYOUT), 32'd1);
            chk("idle_resp", 32'(HRESP), 32'd0);
            chk("idle_rdata", HRDATA, 32'd0);
         end
         if (HSEL && HREADYOUT && HTRANS[1]) begin
            pend    = 1'b1;
            low_cnt = 0;
         end
      end
   end

   // Drives one address phase, waits for the accepting edge, then presents this transfer's write data.
   task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic err,
                       input logic [31:0] rdata);
      int unsigned n = 0;
      HSEL   = sel;
      HTRANS = trans;
      HWRITE = wr;
      HSIZE  = size;
      HADDR  = addr;
      @(negedge HCLK);
      while (!HREADYOUT && n < 50) begin
         @(negedge HCLK);
         n++;
      end
      if (!HREADYOUT) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: got HREADYOUT 0 expected 1 at addr 0x%08h", addr);
      end
      if (sel && trans[1]) begin
         exp_q.push_back('{err, rdata, err ? 32'd1 : EXP_WAITS, next_id});
         next_id++;
      end
      @(posedge HCLK);
      #1;
      HWDATA = wdata;
   endtask

   initial begin
      #1 HRESETn = 1'b0;
      #3;
      chk("rst_ready", 32'(HREADYOUT), 32'd1);
      chk("rst_resp", 32'(HRESP), 32'd0);
      chk("rst_rdata", HRDATA, 32'd0);
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // word write then pipelined read
      xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      // byte and halfword lane merges
      xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, 32'h0);
      xfer(1'b1, 2'b11, 1'b1, 3'd0, 32'h22, 32'h00AA0000, 1'b0, 32'h0);
      xfer(1'b1, 2'b11, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h11AA3344);
      xfer(1'b1, 2'b10, 1'b1, 3'd1, 32'h20, 32'h0000BEEF, 1'b0, 32'h0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h11AABEEF);

      // error responses, with re-accept from ERR2 and memory left intact
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 32'h0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h11AABEEF);
      xfer(1'b1, 2'b10, 1'b1, 3'd1, 32'h21, 32'hFFFFFFFF, 1'b1, 32'h0);
      xfer(1'b1, 2'b10, 1'b1, 3'd3, 32'h20, 32'hFFFFFFFF, 1'b1, 32'h0);
      xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h26, 32'hFFFFFFFF, 1'b1, 32'h0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h11AABEEF);

      // last word in range, and a halfword at the upper lanes
      xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'hFC, 32'hCAFEF00D, 1'b0, 32'h0);
      xfer(1'b1, 2'b10, 1'b1, 3'd1, 32'hFE, 32'h12340000, 1'b0, 32'h0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'hFC, 32'h0, 1'b0, 32'h1234F00D);

      // write/read pair at 0x04 (waited when the wait feature is built in)
      xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h04, 32'h12345678, 1'b0, 32'h0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h04, 32'h0, 1'b0, 32'h12345678);

      // transfers that must not be accepted
      xfer(1'b0, 2'b10, 1'b1, 3'd2, 32'h08, 32'hFFFFFFFF, 1'b0, 32'h0);
      xfer(1'b1, 2'b00, 1'b1, 3'd2, 32'h08, 32'hFFFFFFFF, 1'b0, 32'h0);
      xfer(1'b1, 2'b01, 1'b1, 3'd2, 32'h08, 32'hFFFFFFFF, 1'b0, 32'h0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0, 1'b0, 32'h0);

      // reset asserted while in ERR1
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 32'h0);
      chk("err1_ready", 32'(HREADYOUT), 32'd0);
      chk("err1_resp", 32'(HRESP), 32'd1);
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      #2;
      HRESETn = 1'b0;
      exp_q.delete();
      pend = 1'b0;
      #1;
      chk("midrst_ready", 32'(HREADYOUT), 32'd1);
      chk("midrst_resp", 32'(HRESP), 32'd0);
      chk("midrst_rdata", HRDATA, 32'd0);
      @(posedge HCLK);
      #1 HRESETn = 1'b1;
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h0);

      xfer(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0);
      xfer(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0);
      repeat (6) @(negedge HCLK);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected $finish");
      $fatal(1, "watchdog expired");
   end

endmodule
